interval_timer_ctrl: RTL and testbench
======================================

// Module: interval_timer_ctrl
// PURPOSE
//   Controller that sequences a two-stage counter datapath: a clock-enable prescaler feeding a tick counter.
//   Adds start/stop/pause control, one-shot or periodic mode, and a programmable terminal count.
//   Mouse-driver FSMs use it for PS/2 timeouts and periodic sample intervals, so they need no hand-wired counter chains.
// PARAMETERS
//   PRESCALE_WIDTH  16     width of prescaler register
//   PRESCALE_MAX    49999  prescaler wraps at this value; tick period = PRESCALE_MAX+1 clocks
//   COUNT_WIDTH     8      width of tick counter / TERM_COUNT / COUNT
// PORTS
//   CLK         in   1            system clock, all state on rising edge
//   RESET_N     in   1            asynchronous active-low reset
//   START       in   1            1-cycle command: load TERM_COUNT/PERIODIC, (re)start timing
//   STOP        in   1            1-cycle command: abort, return to IDLE
//   PAUSE       in   1            level: freeze timing while high
//   PERIODIC    in   1            mode, sampled on START: 0 one-shot, 1 auto-reload
//   TERM_COUNT  in   COUNT_WIDTH  ticks per interval, sampled on START; must be nonzero
//   BUSY        out  1            high in RUN or HOLD
//   TICK        out  1            registered 1-cycle prescaler strobe, only while timing
//   TIMEOUT     out  1            registered 1-cycle pulse at interval end
//   COUNT       out  COUNT_WIDTH  ticks elapsed in current interval
//   ERR         out  1            sticky: START seen with TERM_COUNT==0
// BEHAVIOUR
//   Reset (RESET_N low, no clock needed): state IDLE; prescaler, term reg, mode reg, COUNT=0.
//     BUSY=TICK=TIMEOUT=ERR=0.
//   States: IDLE, RUN, HOLD. Command priority each cycle: STOP > START > PAUSE.
//   IDLE:
//     START & TERM_COUNT!=0 -> RUN, latch term/mode, prescaler=0, COUNT=0, ERR=0.
//     START & TERM_COUNT==0 -> stay IDLE, ERR=1, COUNT unchanged.
//   RUN: prescaler +1 per clock. At PRESCALE_MAX, prescaler wraps to 0 (a "wrap edge").
//     Each wrap edge: TICK=1 for the next cycle.
//     If COUNT != term-1: COUNT+1.
//     If COUNT == term-1 (terminal): TIMEOUT=1 for the next cycle, then
//       periodic: COUNT=0, stay RUN;
//       one-shot: COUNT=term, go IDLE (BUSY falls with TIMEOUT rise).
//   HOLD: entered from RUN while PAUSE=1.
//     Prescaler and COUNT frozen; TICK/TIMEOUT stay 0.
//     PAUSE=0 -> RUN, resumes from the frozen value.
//     PAUSE high on the cycle of a wrap edge: pause wins; the wrap is deferred until resume.
//   STOP (any state): -> IDLE, prescaler=0, COUNT=0, TICK/TIMEOUT suppressed that cycle, ERR unchanged.
//   START in RUN/HOLD: restart as from IDLE (reload term/mode, prescaler=0, COUNT=0, no TIMEOUT).
//   Latency: TIMEOUT high T*(PRESCALE_MAX+1) cycles after the START edge, plus the number of paused cycles.
//     It coincides with the final TICK.
//   COUNT in IDLE holds its last value (term after one-shot completion, 0 after STOP/reset).
//   Arithmetic: prescaler compare is equality on PRESCALE_WIDTH bits.
//     term-1 is computed in COUNT_WIDTH bits (term>=1 guaranteed).
//     TERM_COUNT = 2^COUNT_WIDTH-1 is legal.
// TESTING (PRESCALE_MAX=3, COUNT_WIDTH=8)
//   1. START, T=5, one-shot -> TICK every 4 cycles; TIMEOUT 1 cycle at START+20; COUNT=5; BUSY=0 after.
//   2. START, T=2, periodic -> TIMEOUT at +8, +16, +24; COUNT 0,1,0,1...; BUSY stays 1.
//   3. T=5 run, PAUSE high 10 cycles after 6 -> TIMEOUT at START+30; COUNT frozen during HOLD.
//   4. STOP on the terminal wrap cycle -> no TIMEOUT/TICK; COUNT=0; BUSY=0.
//   5. START, TERM_COUNT=0 -> ERR=1, BUSY=0; then START T=1 -> ERR=0, TIMEOUT at +4.
//   6. RESET_N low mid-RUN, between clock edges -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: prescaled tick counter with start/stop/pause control,
// one-shot or periodic mode and a programmable terminal count.
module interval_timer_ctrl #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int PRESCALE_MAX   = 49999,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   pause_i,
  input  logic                   periodic_i,
  input  logic [COUNT_WIDTH-1:0] term_count_i,
  output logic                   busy_o,
  output logic                   tick_o,
  output logic                   timeout_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   err_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [PRESCALE_WIDTH-1:0] PMAX = PRESCALE_WIDTH'(PRESCALE_MAX);

  logic [1:0]                state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d, term_q, term_d;
  logic                      per_q, per_d, err_q, err_d;
  logic                      tick_q, tick_d, timeout_q, timeout_d;
  logic                      wrap, last;

  assign wrap = presc_q == PMAX;
  assign last = count_q == term_q - COUNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    count_d   = count_q;
    term_d    = term_q;
    per_d     = per_q;
    err_d     = err_q;
    tick_d    = 1'b0;
    timeout_d = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
      presc_d = '0;
      count_d = '0;
    end else if (start_i) begin
      presc_d = '0;
      if (term_count_i == '0) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        state_d = RUN;
        term_d  = term_count_i;
        per_d   = periodic_i;
        count_d = '0;
        err_d   = 1'b0;
      end
    end else if (state_q != IDLE) begin
      // Leaving HOLD advances immediately, so a pause costs exactly its own length.
      if (pause_i) begin
        state_d = HOLD;
      end else begin
        state_d = RUN;
        presc_d = wrap ? '0 : presc_q + PRESCALE_WIDTH'(1);
        if (wrap) begin
          tick_d = 1'b1;
          if (last) begin
            timeout_d = 1'b1;
            count_d   = per_q ? '0 : term_q;
            state_d   = per_q ? RUN : IDLE;
          end else begin
            count_d = count_q + COUNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      term_q    <= '0;
      per_q     <= 1'b0;
      err_q     <= 1'b0;
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      term_q    <= term_d;
      per_q     <= per_d;
      err_q     <= err_d;
      tick_q    <= tick_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy_o    = state_q != IDLE;
  assign tick_o    = tick_q;
  assign timeout_o = timeout_q;
  assign count_o   = count_q;
  assign err_o     = err_q;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: directed checks of the interval timer with a 4-clock tick period.
module tb_interval_timer_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0;
  logic [7:0] term = 8'd0;
  logic       busy, tick, timeout, err;
  logic [7:0] count;
  logic [10:0] got, exp;
  int vectors = 0;
  int miscompares = 0;

  interval_timer_ctrl #(.PRESCALE_WIDTH(16), .PRESCALE_MAX(3), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
    .periodic_i(periodic), .term_count_i(term), .busy_o(busy), .tick_o(tick),
    .timeout_o(timeout), .count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  assign got = {busy, tick, timeout, count};

  task step;
    @(posedge clk);
    #1;
  endtask

  task start_cmd(input logic [7:0] t, input logic p);
    term = t;
    periodic = p;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task stop_cmd;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task test_reset;
    #3;
    vectors++;
    if ({got, err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset got=%h exp=000", {got, err});
    end
    rst_n = 1'b1;
    step();
  endtask

  task test_oneshot;
    start_cmd(8'd5, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      exp = {k < 20, k % 4 == 0, k == 20, 8'(k / 4)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL oneshot k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    step();
    vectors++;
    if (got !== {3'b000, 8'd5}) begin
      miscompares++;
      $display("FAIL oneshot_idle got=%h exp=%h", got, {3'b000, 8'd5});
    end
  endtask

  task test_periodic;
    start_cmd(8'd2, 1'b1);
    for (int k = 1; k <= 26; k++) begin
      step();
      exp = {1'b1, k % 4 == 0, k % 8 == 0, 8'((k / 4) % 2)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL periodic k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    stop_cmd();
    vectors++;
    if (got !== 11'h000) begin
      miscompares++;
      $display("FAIL periodic_stop got=%h exp=000", got);
    end
  endtask

  task test_pause;
    int e;
    start_cmd(8'd5, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      step();
      e = (k <= 6) ? k : (k <= 16) ? 6 : k - 10;
      exp = {e < 20, e % 4 == 0 && !(k > 6 && k <= 16), e == 20, 8'(e / 4)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL pause k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 6) pause = 1'b1;
      if (k == 16) pause = 1'b0;
    end
  endtask

  task test_stop_terminal;
    start_cmd(8'd2, 1'b0);
    repeat (7) step();
    stop_cmd();
    vectors++;
    if (got !== 11'h000) begin
      miscompares++;
      $display("FAIL stop_terminal got=%h exp=000", got);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (got !== 11'h000) begin
        miscompares++;
        $display("FAIL stop_after k=%0d got=%h exp=000", k, got);
      end
    end
  endtask

  task test_back_to_back;
    start_cmd(8'd3, 1'b1);
    repeat (6) step();
    start_cmd(8'd1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = {k < 4, k == 4, k == 4, 8'(k == 4)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL restart k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task test_err;
    start_cmd(8'd0, 1'b0);
    vectors++;
    if ({got, err} !== {3'b000, 8'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL err_set got=%h exp=%h", {got, err}, {3'b000, 8'd1, 1'b1});
    end
    step();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
    start_cmd(8'd1, 1'b0);
    vectors++;
    if ({busy, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL err_clear got=%b exp=10", {busy, err});
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = {k < 4, k == 4, k == 4, 8'(k == 4)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL err_t1 k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task test_async_reset;
    start_cmd(8'd0, 1'b0);
    start_cmd(8'd5, 1'b0);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({got, err} !== 12'h000) begin
      miscompares++;
      $display("FAIL async_reset got=%h exp=000", {got, err});
    end
    #3 rst_n = 1'b1;
    repeat (6) step();
    vectors++;
    if ({got, err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_release got=%h exp=000", {got, err});
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_stop_terminal();
    test_back_to_back();
    test_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
